pwm_peripheral: RTL and testbench

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_timebase.sv | 32 +++
 rtl/pwm_peripheral.sv | 73 +++++++
 tb/tb_pwm_peripheral.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, output-mode decode and PWM level helper for the PWM peripheral.
package pwm_pkg;

  localparam int PWM_WIDTH       = 8;
  localparam int NUM_OUT         = 16;
  localparam int CLK_DIV_DEFAULT = 4;

  localparam logic [PWM_WIDTH-1:0] DUTY_FULL = '1;

  typedef enum logic [1:0] {
    OUT_OFF  = 2'd0,
    OUT_HIGH = 2'd1,
    OUT_PWM  = 2'd2
  } out_mode_e;

  function automatic out_mode_e decode_mode(input logic enable, input logic pwm_sel);
    if (!enable)      return OUT_OFF;
    else if (!pwm_sel) return OUT_HIGH;
    else              return OUT_PWM;
  endfunction

  // Full scale is forced high so 0xFF never shows a one-count low glitch.
  function automatic logic pwm_level(input logic [PWM_WIDTH-1:0] cnt,
                                     input logic [PWM_WIDTH-1:0] duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus shared 8-bit PWM counter; tick and wrap are combinational strobes.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 tick,
  output logic [PWM_WIDTH-1:0] pwm_cnt,
  output logic                 wrap
);

  localparam int              PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] prescaler;

  assign tick = (prescaler == PRE_LAST);
  assign wrap = tick && (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: per-bit off/high/PWM mux driven by one shared timebase.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         en_reg_out_7_0,
  input  logic [7:0]         en_reg_out_15_8,
  input  logic [7:0]         en_reg_pwm_7_0,
  input  logic [7:0]         en_reg_pwm_15_8,
  input  logic [7:0]         pwm_duty_cycle,
  output logic [NUM_OUT-1:0] out,
  output logic               period_start
);

  logic                 tick;
  logic                 wrap;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] cnt_nxt;
  logic [PWM_WIDTH-1:0] duty_active;
  logic [PWM_WIDTH-1:0] duty_nxt;
  logic [NUM_OUT-1:0]   en_all;
  logic [NUM_OUT-1:0]   pwm_all;
  logic [NUM_OUT-1:0]   out_nxt;
  logic [NUM_OUT-1:0]   out_p0;
  logic                 pwm_wave;

  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .pwm_cnt (pwm_cnt),
    .wrap    (wrap)
  );

  assign en_all  = {en_reg_out_15_8, en_reg_out_7_0};
  assign pwm_all = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Output is built from the post-edge counter and duty so the first value of a
  // new period lands in the same clock as period_start.
  assign cnt_nxt  = tick ? pwm_cnt + PWM_WIDTH'(1) : pwm_cnt;
  assign duty_nxt = wrap ? pwm_duty_cycle : duty_active;
  assign pwm_wave = pwm_level(cnt_nxt, duty_nxt);

  always_comb begin
    out_nxt = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      case (decode_mode(en_all[i], pwm_all[i]))
        OUT_HIGH: out_nxt[i] = 1'b1;
        OUT_PWM:  out_nxt[i] = pwm_wave;
        default:  out_nxt[i] = 1'b0;
      endcase
    end
  end

  // ---- stage p0: registered drive values, shadow duty, period marker ----
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_active  <= '0;
      out_p0       <= '0;
      period_start <= 1'b0;
    end else begin
      duty_active  <= duty_nxt;
      out_p0       <= out_nxt;
      period_start <= wrap;
    end
  end

  assign out = out_p0;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed plus randomized bench for pwm_peripheral against a clock-count reference model.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference state: n = clock edges since reset release.
  int          n = 0;
  logic [7:0]  duty_m = 8'h00;
  logic [15:0] out_m = 16'h0000;
  logic        ps_m = 1'b0;
  int          hi_cnt[16];

  function automatic int cur_cnt(input int edges);
    return (edges / CLK_DIV) % 256;
  endfunction

  function automatic logic [15:0] expect_out(input logic [15:0] en, input logic [15:0] mode,
                                             input int edges, input logic [7:0] d);
    logic [15:0] r;
    logic        w;
    w = (d == 8'hFF) || (cur_cnt(edges) < int'(d));
    for (int i = 0; i < 16; i++) r[i] = en[i] & (~mode[i] | w);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      n = 0; duty_m = 8'h00; out_m = 16'h0000; ps_m = 1'b0;
    end else begin
      n++;
      ps_m = (n % PERIOD == 0);
      if (ps_m) duty_m = duty;
      out_m = expect_out({eo_hi, eo_lo}, {ep_hi, ep_lo}, n, duty_m);
    end
    @(negedge clk);
    check("out_model", {16'h0, out}, {16'h0, out_m});
    check("period_start_model", {31'h0, period_start}, {31'h0, ps_m});
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic wait_ps();
    int b;
    b = 0;
    step();
    while (period_start !== 1'b1 && b < 3000) begin
      step();
      b++;
    end
    check("wait_period_start", {31'h0, period_start}, 32'h1);
  endtask

  task automatic tally();
    for (int i = 0; i < 16; i++) hi_cnt[i] += int'(out[i]);
  endtask

  // Counts high clocks per bit over one full period; duty input changes to nd
  // once the model counter reaches chg_at (0 means right after period_start).
  task automatic count_period(input logic [7:0] nd, input int chg_at);
    bit changed;
    for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
    wait_ps();
    tally();
    changed = 1'b0;
    if (chg_at == 0) begin duty = nd; changed = 1'b1; end
    for (int k = 1; k < PERIOD; k++) begin
      step();
      tally();
      if (!changed && cur_cnt(n) == chg_at) begin duty = nd; changed = 1'b1; end
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    eo_lo = 8'h00; eo_hi = 8'h00; ep_lo = 8'h00; ep_hi = 8'h00; duty = 8'h00;
    run(3);
    check("reset_out", {16'h0, out}, 32'h0);
    check("reset_ps", {31'h0, period_start}, 32'h0);
    rst = 1'b0;

    // All outputs plain high.
    eo_lo = 8'hFF; eo_hi = 8'hFF;
    step();
    check("const_high_first", {16'h0, out}, 32'hFFFF);
    run(20);
    check("const_high_hold", {16'h0, out}, 32'hFFFF);

    // All outputs in PWM mode at 50%; first period still runs at duty 0.
    ep_lo = 8'hFF; ep_hi = 8'hFF; duty = 8'h80;
    count_period(8'h00, 0);
    check("duty80_hi_bit0", hi_cnt[0], 512);
    check("duty80_hi_bit15", hi_cnt[15], 512);
    check("duty80_hi_bit8", hi_cnt[8], 512);

    count_period(8'hFF, 0);
    check("duty00_hi", hi_cnt[0], 0);
    count_period(8'h40, 0);
    check("dutyFF_hi", hi_cnt[0], PERIOD);
    check("dutyFF_hi_bit9", hi_cnt[9], PERIOD);

    // Mid-period duty change must not alter the running period.
    count_period(8'hC0, 100);
    check("duty40_midchange_hi", hi_cnt[0], 256);
    count_period(8'h80, 0);
    check("dutyC0_hi", hi_cnt[0], 768);

    // Mixed enable / mode pattern on the low byte.
    eo_lo = 8'h0F; ep_lo = 8'h05; eo_hi = 8'h00; ep_hi = 8'h00;
    count_period(8'h80, 0);
    check("mix_bit0_pwm", hi_cnt[0], 512);
    check("mix_bit2_pwm", hi_cnt[2], 512);
    check("mix_bit1_high", hi_cnt[1], PERIOD);
    check("mix_bit3_high", hi_cnt[3], PERIOD);
    check("mix_bit4_off", hi_cnt[4], 0);
    check("mix_bit7_off", hi_cnt[7], 0);
    check("mix_bit12_off", hi_cnt[12], 0);

    // Mid-period reset with junk data inputs.
    eo_lo = 8'hFF; ep_lo = 8'hFF; eo_hi = 8'hFF; ep_hi = 8'hFF;
    k = 0;
    while (cur_cnt(n) != 50 && k < 2000) begin step(); k++; end
    check("reach_cnt50", cur_cnt(n), 50);
    rst = 1'b1;
    eo_lo = 8'($urandom); eo_hi = 8'($urandom); duty = 8'($urandom);
    step();
    check("midreset_out", {16'h0, out}, 32'h0);
    check("midreset_ps", {31'h0, period_start}, 32'h0);
    run(2);
    rst = 1'b0;
    eo_lo = 8'hFF; eo_hi = 8'hFF; duty = 8'h80;
    k = 0;
    do begin step(); k++; end while (period_start !== 1'b1 && k < 2000);
    check("release_to_ps", k, PERIOD);

    // Randomized traffic, duty changing every clock so boundaries see fresh values.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        eo_lo = 8'($urandom); eo_hi = 8'($urandom);
        ep_lo = 8'($urandom); ep_hi = 8'($urandom);
      end
      duty = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF)
                                         : 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
